// File: rtl/data_memory.sv
// Word-addressed data RAM with same-cycle bus reads, a posted-write buffer and a loader port.
// Optional macro DATA_MEMORY_OOR_CHECK_EN adds out-of-range address detection (oor_err).
module data_memory #(
    parameter int ADDR_WIDTH = 10,
    parameter int WB_DEPTH   = 2,
    localparam int CNT_W     = $clog2(WB_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    inout  wire  [31:0]           data_bus,
    input  logic [29:0]           data_address,
    input  logic                  data_rw,
    input  logic                  data_cs,
    input  logic                  dbg_valid,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [31:0]           dbg_wdata,
    output logic                  dbg_ready,
    output logic                  dbg_rvalid,
    output logic [31:0]           dbg_rdata,
`ifdef DATA_MEMORY_OOR_CHECK_EN
    output logic                  oor_err,
`endif
    output logic [CNT_W-1:0]      wb_count
);

    logic [31:0]           mem_q [0:(2**ADDR_WIDTH)-1];
    logic [ADDR_WIDTH-1:0] wb_idx_q  [0:WB_DEPTH-1];
    logic [ADDR_WIDTH-1:0] wb_idx_d  [0:WB_DEPTH-1];
    logic [31:0]           wb_data_q [0:WB_DEPTH-1];
    logic [31:0]           wb_data_d [0:WB_DEPTH-1];
    logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_tmp;
    logic                  dbg_rvalid_q, dbg_rvalid_d;
    logic [31:0]           dbg_rdata_q, dbg_rdata_d;

    logic [ADDR_WIDTH-1:0] idx;
    logic                  bus_rd, push, push_ok, pop, full, oor_hit;
    logic                  dbg_fire, mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [31:0]           mem_wdata, rd_data;

    assign idx       = data_address[ADDR_WIDTH-1:0];
    assign bus_rd    = data_cs && !data_rw;
    assign full      = (cnt_q == CNT_W'(WB_DEPTH));
    assign dbg_ready = !data_cs && (cnt_q == '0);
    assign dbg_fire  = dbg_valid && dbg_ready && !rst;

`ifdef DATA_MEMORY_OOR_CHECK_EN
    logic oor_err_q, oor_err_d;
    assign oor_hit   = data_cs && (data_address[29:ADDR_WIDTH] != '0);
    assign oor_err_d = oor_err_q || oor_hit;
    assign oor_err   = oor_err_q;
`else
    assign oor_hit   = 1'b0;
`endif

    // A drain never steals the array from a same-cycle bus read; reset discards pending work.
    assign push    = data_cs && data_rw && !oor_hit && !rst;
    assign pop     = (cnt_q != '0) && !bus_rd && !rst;
    assign push_ok = push && (!full || pop);

    always_comb begin
        wb_idx_d  = wb_idx_q;
        wb_data_d = wb_data_q;
        cnt_tmp   = pop ? (cnt_q - 1'b1) : cnt_q;
        if (pop) begin
            for (int i = 0; i < WB_DEPTH - 1; i++) begin
                wb_idx_d[i]  = wb_idx_q[i+1];
                wb_data_d[i] = wb_data_q[i+1];
            end
        end
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (push_ok && (CNT_W'(i) == cnt_tmp)) begin
                wb_idx_d[i]  = idx;
                wb_data_d[i] = data_bus;
            end
        end
        cnt_d = cnt_tmp + CNT_W'(push_ok);
    end

    // Entries are kept oldest-first, so the last match in the scan is the youngest.
    always_comb begin
        rd_data = mem_q[idx];
        for (int i = 0; i < WB_DEPTH; i++) begin
            if ((CNT_W'(i) < cnt_q) && (wb_idx_q[i] == idx)) begin
                rd_data = wb_data_q[i];
            end
        end
        if (oor_hit) begin
            rd_data = 32'h0;
        end
    end

    assign data_bus = (bus_rd && !rst) ? rd_data : 32'bz;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = dbg_addr;
        mem_wdata = dbg_wdata;
        if (pop) begin
            mem_we    = 1'b1;
            mem_waddr = wb_idx_q[0];
            mem_wdata = wb_data_q[0];
        end else if (dbg_fire && dbg_we) begin
            mem_we = 1'b1;
        end
    end

    always_comb begin
        dbg_rvalid_d = dbg_fire && !dbg_we;
        dbg_rdata_d  = dbg_rvalid_d ? mem_q[dbg_addr] : dbg_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
        wb_idx_q  <= wb_idx_d;
        wb_data_q <= wb_data_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            dbg_rvalid_q <= 1'b0;
            dbg_rdata_q  <= 32'h0;
`ifdef DATA_MEMORY_OOR_CHECK_EN
            oor_err_q    <= 1'b0;
`endif
        end else begin
            cnt_q        <= cnt_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            dbg_rdata_q  <= dbg_rdata_d;
`ifdef DATA_MEMORY_OOR_CHECK_EN
            oor_err_q    <= oor_err_d;
`endif
        end
    end

    assign wb_count   = cnt_q;
    assign dbg_rvalid = dbg_rvalid_q;
    assign dbg_rdata  = dbg_rdata_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (push && full && !pop) begin
            $error("data_memory: posted-write buffer overflow, write to index %0d dropped", idx);
        end
    end
`endif

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: loader port, forwarding, draining, contention and reset.
// The out-of-range scenario runs only when DATA_MEMORY_OOR_CHECK_EN is defined.
module tb_data_memory;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [29:0]   data_address;
    logic          data_rw, data_cs;
    logic          dbg_valid, dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [31:0]   dbg_wdata;
    logic          dbg_ready, dbg_rvalid;
    logic [31:0]   dbg_rdata;
    logic [1:0]    wb_count;
    logic [31:0]   bus_drv;
    logic          bus_oe;
    wire  [31:0]   data_bus;
`ifdef DATA_MEMORY_OOR_CHECK_EN
    logic          oor_err;
`endif

    int checks = 0;
    int fails  = 0;

    assign data_bus = bus_oe ? bus_drv : 32'bz;

    always #5 clk = ~clk;

    data_memory #(.ADDR_WIDTH(AW), .WB_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .data_bus(data_bus), .data_address(data_address),
        .data_rw(data_rw), .data_cs(data_cs), .dbg_valid(dbg_valid), .dbg_we(dbg_we),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ready(dbg_ready),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
`ifdef DATA_MEMORY_OOR_CHECK_EN
        .oor_err(oor_err),
`endif
        .wb_count(wb_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        data_cs = 1'b0; data_rw = 1'b0; bus_oe = 1'b0;
    endtask

    task automatic bus_write(input logic [29:0] a, input logic [31:0] d);
        data_cs = 1'b1; data_rw = 1'b1; data_address = a; bus_drv = d; bus_oe = 1'b1;
    endtask

    task automatic bus_read(input logic [29:0] a);
        data_cs = 1'b1; data_rw = 1'b0; data_address = a; bus_oe = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (wb_count !== 2'd0) begin fails++; $display("FAIL reset_wb_count got %0d want 0", wb_count); end
        checks++; if (dbg_rvalid !== 1'b0) begin fails++; $display("FAIL reset_rvalid got %b want 0", dbg_rvalid); end
        checks++; if (dbg_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h want 0", dbg_rdata); end
        checks++; if (dbg_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", dbg_ready); end
    endtask

    task automatic test_loader();
        dbg_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 10'd5; dbg_wdata = 32'hDEADBEEF;
        #1;
        checks++; if (dbg_ready !== 1'b1) begin fails++; $display("FAIL ldr_wr_ready got %b want 1", dbg_ready); end
        tick();
        dbg_we = 1'b0;
        #1;
        checks++; if (dbg_ready !== 1'b1) begin fails++; $display("FAIL ldr_rd_ready got %b want 1", dbg_ready); end
        tick();
        dbg_valid = 1'b0;
        checks++; if (dbg_rvalid !== 1'b1) begin fails++; $display("FAIL ldr_rvalid got %b want 1", dbg_rvalid); end
        checks++; if (dbg_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL ldr_rdata got %h want deadbeef", dbg_rdata); end
        tick();
        checks++; if (dbg_rvalid !== 1'b0) begin fails++; $display("FAIL ldr_rvalid_pulse got %b want 0", dbg_rvalid); end
        checks++; if (dbg_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL ldr_rdata_hold got %h want deadbeef", dbg_rdata); end
    endtask

    task automatic test_forward();
        bus_write(30'd7, 32'h11223344);
        tick();
        bus_read(30'd7);
        #1;
        checks++; if (data_bus !== 32'h11223344) begin fails++; $display("FAIL fwd_data got %h want 11223344", data_bus); end
        checks++; if (wb_count !== 2'd1) begin fails++; $display("FAIL fwd_count got %0d want 1", wb_count); end
        tick();
        bus_idle();
        checks++; if (wb_count !== 2'd1) begin fails++; $display("FAIL fwd_no_drain got %0d want 1", wb_count); end
        tick();
        checks++; if (wb_count !== 2'd0) begin fails++; $display("FAIL fwd_drained got %0d want 0", wb_count); end
        bus_read(30'd7);
        #1;
        checks++; if (data_bus !== 32'h11223344) begin fails++; $display("FAIL fwd_array got %h want 11223344", data_bus); end
        tick();
        bus_idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [0:3];
        vals[0] = 32'hA0000003; vals[1] = 32'hA0000004; vals[2] = 32'hA0000005; vals[3] = 32'hA0000006;
        for (int i = 0; i < 4; i++) begin
            bus_write(30'(3 + i), vals[i]);
            tick();
            checks++; if (wb_count !== 2'd1) begin fails++; $display("FAIL b2b_count%0d got %0d want 1", i, wb_count); end
        end
        bus_idle();
        tick();
        checks++; if (wb_count !== 2'd0) begin fails++; $display("FAIL b2b_drain got %0d want 0", wb_count); end
        dbg_valid = 1'b1; dbg_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dbg_addr = AW'(3 + i);
            tick();
            checks++; if (dbg_rvalid !== 1'b1) begin fails++; $display("FAIL b2b_rvalid%0d got %b want 1", i, dbg_rvalid); end
            checks++; if (dbg_rdata !== vals[i]) begin fails++; $display("FAIL b2b_rdata%0d got %h want %h", i, dbg_rdata, vals[i]); end
        end
        dbg_valid = 1'b0;
        tick();
        checks++; if (dbg_rvalid !== 1'b0) begin fails++; $display("FAIL b2b_rvalid_end got %b want 0", dbg_rvalid); end
    endtask

    task automatic test_contention();
        bus_write(30'd9, 32'h99AABBCC);
        dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 10'd9;
        #1;
        checks++; if (dbg_ready !== 1'b0) begin fails++; $display("FAIL cont_ready_cs got %b want 0", dbg_ready); end
        tick();
        bus_idle();
        #1;
        checks++; if (dbg_ready !== 1'b0) begin fails++; $display("FAIL cont_ready_wb got %b want 0", dbg_ready); end
        tick();
        checks++; if (dbg_ready !== 1'b1) begin fails++; $display("FAIL cont_ready_up got %b want 1", dbg_ready); end
        tick();
        dbg_valid = 1'b0;
        checks++; if (dbg_rvalid !== 1'b1) begin fails++; $display("FAIL cont_rvalid got %b want 1", dbg_rvalid); end
        checks++; if (dbg_rdata !== 32'h99AABBCC) begin fails++; $display("FAIL cont_rdata got %h want 99aabbcc", dbg_rdata); end
        tick();
    endtask

    task automatic test_reset_mid();
        dbg_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 10'd2; dbg_wdata = 32'h22222222;
        tick();
        dbg_valid = 1'b0;
        bus_write(30'd2, 32'hBAD00002);
        tick();
        bus_idle();
        rst = 1'b1;
        dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 10'd2;
        tick();
        checks++; if (wb_count !== 2'd0) begin fails++; $display("FAIL rstmid_count got %0d want 0", wb_count); end
        checks++; if (dbg_rvalid !== 1'b0) begin fails++; $display("FAIL rstmid_rvalid got %b want 0", dbg_rvalid); end
        bus_write(30'd10, 32'hBAD0000A);
        dbg_valid = 1'b1; dbg_we = 1'b0;
        tick();
        rst = 1'b0;
        bus_idle();
        checks++; if (wb_count !== 2'd0) begin fails++; $display("FAIL rst_busw_count got %0d want 0", wb_count); end
        checks++; if (dbg_rvalid !== 1'b0) begin fails++; $display("FAIL rst_ldr_rvalid got %b want 0", dbg_rvalid); end
        tick();
        dbg_valid = 1'b0;
        checks++; if (dbg_rdata !== 32'h22222222) begin fails++; $display("FAIL rstmid_keep got %h want 22222222", dbg_rdata); end
        tick();
    endtask

`ifdef DATA_MEMORY_OOR_CHECK_EN
    task automatic test_oor();
        dbg_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 10'd0; dbg_wdata = 32'h5A5A5A5A;
        tick();
        dbg_valid = 1'b0;
        checks++; if (oor_err !== 1'b0) begin fails++; $display("FAIL oor_initial got %b want 0", oor_err); end
        bus_read(30'h400);
        #1;
        checks++; if (data_bus !== 32'h0) begin fails++; $display("FAIL oor_rdata got %h want 0", data_bus); end
        tick();
        bus_idle();
        checks++; if (oor_err !== 1'b1) begin fails++; $display("FAIL oor_set got %b want 1", oor_err); end
        tick();
        checks++; if (oor_err !== 1'b1) begin fails++; $display("FAIL oor_sticky got %b want 1", oor_err); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (oor_err !== 1'b0) begin fails++; $display("FAIL oor_clear got %b want 0", oor_err); end
    endtask
`endif

    initial begin
        rst = 1'b1; data_address = '0; data_rw = 1'b0; data_cs = 1'b0; bus_drv = '0; bus_oe = 1'b0;
        dbg_valid = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_loader();
        test_forward();
        test_back_to_back();
        test_contention();
        test_reset_mid();
`ifdef DATA_MEMORY_OOR_CHECK_EN
        test_oor();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Word-addressed data RAM acting as the responder on the core's data bus. Signals: data_bus (inout), data_address, data_rw, data_cs.
- Serves combinational same-cycle reads to the MEM stage.
- Absorbs bus writes into a small posted-write buffer that drains into the array in free cycles.
- A secondary valid/ready debug/loader port shares the array for program loading and inspection.

Parameters:
- ADDR_WIDTH, 10, number of word-index bits; array holds 2**ADDR_WIDTH 32-bit words.
- WB_DEPTH, 2, posted-write buffer entries (minimum 2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- data_bus  inout  32  read data driven by this block; write data sampled from the initiator.
- data_address  in  30  word address; low ADDR_WIDTH bits index the array.
- data_rw  in  1  1 = write, 0 = read (valid when data_cs=1).
- data_cs  in  1  bus access this cycle.
- dbg_valid  in  1  loader request valid.
- dbg_we  in  1  loader request is a write.
- dbg_addr  in  ADDR_WIDTH  loader word index.
- dbg_wdata  in  32  loader write data.
- dbg_ready  out  1  loader request accepted this cycle.
- dbg_rvalid  out  1  one-cycle pulse, loader read data valid.
- dbg_rdata  out  32  loader read data, registered.
- wb_count  out  $clog2(WB_DEPTH+1)  current posted-write buffer occupancy.

Behaviour:
- Index: idx = data_address[ADDR_WIDTH-1:0]. Upper address bits are ignored unless the optional feature is enabled.
- Bus read (cs=1, rw=0):
  - data_bus is driven combinationally in the same cycle, zero latency.
  - Value is the youngest buffer entry whose index matches idx; otherwise array[idx].
- data_bus is high-Z whenever cs=0 or rw=1; never contend with the initiator.
- Bus write (cs=1, rw=1): {idx, data_bus} is pushed into the buffer at the clock edge. No stall; the bus has no wait mechanism.
- Drain: at each edge, if the buffer is non-empty and the current cycle is not a bus read:
  - the head entry is written to the array and popped;
  - push and pop in the same cycle are legal (occupancy unchanged).
- Overflow: with these rules occupancy never exceeds 1 with WB_DEPTH>=2. A push while full without a same-cycle pop is a design error; simulation issues $error and drops the write.
- Array port priority per cycle: bus read > buffer drain > loader.
- Loader handshake:
  - dbg_ready = !data_cs && wb_count==0 (combinational).
  - A transfer occurs on dbg_valid && dbg_ready at the edge.
  - Loader write: array[dbg_addr] <= dbg_wdata at that edge.
  - Loader read: dbg_rdata <= array[dbg_addr]; dbg_rvalid=1 in the next cycle only, otherwise 0.
  - dbg_rdata holds its value until the next loader read.
  - Requester keeps dbg_valid and request fields stable until accepted.
  - Back-to-back loader reads give one response per cycle.
- Loader write and bus read can never coincide, since dbg_ready is low while cs=1.
- Reset values: buffer empty, wb_count=0, dbg_rvalid=0, dbg_rdata=0, data_bus high-Z.
- Array contents are not cleared by reset.
- Reset mid-operation:
  - un-drained posted writes are discarded;
  - a loader read accepted in the reset cycle produces no dbg_rvalid;
  - bus writes during rst are ignored.

Optional Feature:
- Macro: DATA_MEMORY_OOR_CHECK_EN.
- With the macro defined:
  - adds output oor_err (1 bit, reset 0);
  - sticky set when cs=1 and data_address[29:ADDR_WIDTH] != 0;
  - out-of-range writes are not pushed, out-of-range reads drive 32'h0;
  - cleared only by rst.
- Without the macro: port absent; upper bits ignored and the address aliases modulo array size.

Test Plan:
- Loader writes 32'hDEADBEEF to index 5, then loader reads index 5 -> dbg_ready=1 on both requests; dbg_rvalid pulses one cycle after the read with dbg_rdata=32'hDEADBEEF.
- Bus write 32'h11223344 to address 7, bus read address 7 the next cycle -> data_bus=32'h11223344 via forwarding, wb_count=1 during the read; the entry drains in the following idle cycle and wb_count becomes 0.
- Bus writes to addresses 3,4,5,6 on consecutive cycles -> wb_count stays 1, no $error; the final idle cycle drains; loader reads of 3..6 return the written values.
- Bus write to address 9 in the cycle dbg_valid=1 -> dbg_ready=0; dbg_ready rises only after cs=0 and the buffer is empty; the loader read of 9 returns the bus data.
- Bus write to address 2, then rst asserted before any idle cycle -> wb_count=0 after reset; array[2] keeps its old value; dbg_rvalid=0.
- With DATA_MEMORY_OOR_CHECK_EN and ADDR_WIDTH=10, bus read at address 30'h400 -> data_bus=0, oor_err=1 on the next cycle and remains 1 until rst.
